fixed_clamp_act: RTL and testbench

Parametrised, pipelined fixed-point clamp activation covering ReLU, ReLU6 and hardtanh. Bounds are correctly scaled by the fractional width, and the block supports independent input/output precision with requantisation and saturation. It sits between linear/conv stages and the next streaming consumer in the activation-layer library. It uses the standard valid/ready dataflow handshake with a two-stage registered pipeline and full back-pressure.

---
 rtl/fixed_clamp_act.sv | 147 ++++++++++++++
 tb/tb_fixed_clamp_act.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fixed_clamp_act.sv
// Two-stage valid/ready clamp activation (ReLU / ReLU6 / hardtanh) with requantisation and saturation.
// FIXED_CLAMP_ACT_SAT_CNT_EN builds the upper-bound hit counter; otherwise sat_count is tied to 0.
module fixed_clamp_act #(
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_IN_0_PRECISION_1       = 3,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int DATA_OUT_0_PRECISION_0       = 8,
  parameter int DATA_OUT_0_PRECISION_1       = 3,
  parameter int DATA_OUT_0_TENSOR_SIZE_DIM_0 = DATA_IN_0_TENSOR_SIZE_DIM_0,
  parameter int DATA_OUT_0_TENSOR_SIZE_DIM_1 = DATA_IN_0_TENSOR_SIZE_DIM_1,
  parameter int DATA_OUT_0_PARALLELISM_DIM_0 = DATA_IN_0_PARALLELISM_DIM_0,
  parameter int DATA_OUT_0_PARALLELISM_DIM_1 = DATA_IN_0_PARALLELISM_DIM_1,
  parameter int MODE         = 1,
  parameter int CLAMP_HI_INT = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_IN_0_PRECISION_0-1:0]  data_in_0,
  input  logic data_in_0_valid,
  output logic data_in_0_ready,
  output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic data_out_0_valid,
  input  logic data_out_0_ready,
  input  logic sat_clr,
  output logic [31:0] sat_count
);

  localparam int N    = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int IW   = DATA_IN_0_PRECISION_0;
  localparam int IF   = DATA_IN_0_PRECISION_1;
  localparam int OW   = DATA_OUT_0_PRECISION_0;
  localparam int OF   = DATA_OUT_0_PRECISION_1;
  localparam int SH_L = (OF >= IF) ? (OF - IF) : 0;
  localparam int SH_R = (IF > OF) ? (IF - OF) : 0;
  // Wide enough for the left-shifted input and the output range, plus a sign bit.
  localparam int WW   = (((IW + SH_L) > OW) ? (IW + SH_L) : OW) + 1;

  localparam longint HI_VAL = longint'(CLAMP_HI_INT) <<< IF;
  localparam longint IN_MAX = (longint'(1) <<< (IW - 1)) - 1;
  localparam logic signed [IW-1:0] HI = IW'(HI_VAL);
  localparam logic signed [IW-1:0] LO = (MODE == 2) ? IW'(-HI_VAL) : '0;
  localparam logic signed [WW-1:0] OMAX = WW'((longint'(1) <<< (OW - 1)) - 1);
  localparam logic signed [WW-1:0] OMIN = ~OMAX;

  generate
    if (IW < 2) begin : g_chk_iw
      $error("fixed_clamp_act: DATA_IN_0_PRECISION_0 must be >= 2");
    end
    if (DATA_OUT_0_PARALLELISM_DIM_0 * DATA_OUT_0_PARALLELISM_DIM_1 != N) begin : g_chk_par
      $error("fixed_clamp_act: output parallelism product must equal input parallelism product");
    end
    if (MODE < 0 || MODE > 2) begin : g_chk_mode
      $error("fixed_clamp_act: MODE must be 0, 1 or 2");
    end
    if (CLAMP_HI_INT < 0 || HI_VAL > IN_MAX) begin : g_chk_hi
      $error("fixed_clamp_act: CLAMP_HI_INT << DATA_IN_0_PRECISION_1 does not fit the signed input width");
    end
  endgenerate

  logic s1_valid, s2_valid, s2_ready_in, s1_adv, in_fire, out_fire;
  logic [N*IW-1:0] s1_dat, clamp_dat;
  logic [N*OW-1:0] s2_dat, quant_dat;
  logic s1_hit, s2_hit, clamp_hit;
  logic signed [IW-1:0] x;
  logic signed [WW-1:0] w;

  assign s2_ready_in      = !s2_valid || data_out_0_ready;
  assign data_in_0_ready  = !s1_valid || s2_ready_in;
  assign in_fire          = data_in_0_valid && data_in_0_ready;
  assign s1_adv           = s1_valid && s2_ready_in;
  assign out_fire         = s2_valid && data_out_0_ready;
  assign data_out_0       = s2_dat;
  assign data_out_0_valid = s2_valid;

  // Clamp in the input domain; only a strict overshoot of HI counts as a hit.
  always_comb begin
    clamp_dat = '0;
    clamp_hit = 1'b0;
    x         = '0;
    for (int i = 0; i < N; i++) begin
      x = $signed(data_in_0[i*IW +: IW]);
      if (x < LO) begin
        x = LO;
      end else if (MODE != 0 && x > HI) begin
        x = HI;
        clamp_hit = 1'b1;
      end
      clamp_dat[i*IW +: IW] = x;
    end
  end

  // Requantise: realign the binary point (right shift floors), then saturate.
  always_comb begin
    quant_dat = '0;
    w         = '0;
    for (int i = 0; i < N; i++) begin
      w = {{(WW-IW){s1_dat[i*IW+IW-1]}}, s1_dat[i*IW +: IW]};
      w = w <<< SH_L;
      w = w >>> SH_R;
      if (w > OMAX)      quant_dat[i*OW +: OW] = OMAX[OW-1:0];
      else if (w < OMIN) quant_dat[i*OW +: OW] = OMIN[OW-1:0];
      else               quant_dat[i*OW +: OW] = w[OW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_dat   <= '0;
      s2_dat   <= '0;
      s1_hit   <= 1'b0;
      s2_hit   <= 1'b0;
    end else begin
      if (data_in_0_ready) s1_valid <= data_in_0_valid;
      if (in_fire) begin
        s1_dat <= clamp_dat;
        s1_hit <= clamp_hit;
      end
      if (s2_ready_in) s2_valid <= s1_valid;
      if (s1_adv) begin
        s2_dat <= quant_dat;
        s2_hit <= s1_hit;
      end
    end
  end

`ifdef FIXED_CLAMP_ACT_SAT_CNT_EN
  logic [31:0] sat_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        sat_cnt <= '0;
    else if (sat_clr)                               sat_cnt <= '0;
    else if (out_fire && s2_hit && sat_cnt != '1)   sat_cnt <= sat_cnt + 32'd1;
  end

  assign sat_count = sat_cnt;
`else
  logic unused_sat;
  assign unused_sat = sat_clr ^ s2_hit ^ out_fire;
  assign sat_count  = '0;
`endif

endmodule

// File: tb/tb_fixed_clamp_act.sv
// Bench for fixed_clamp_act: five 4-lane configurations share one stimulus stream and a queue-based reference model.
module tb_fixed_clamp_act;

`ifdef FIXED_CLAMP_ACT_SAT_CNT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // Per-instance configuration: r6, hardtanh(1), r6->4frac, r6->5frac, relu->1frac.
  localparam int CFG_MODE [5] = '{1, 2, 1, 1, 0};
  localparam int CFG_HI   [5] = '{6, 1, 6, 6, 6};
  localparam int CFG_OF   [5] = '{3, 3, 4, 5, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] din = '0;
  logic din_vld = 1'b0, dout_rdy = 1'b1, sat_clr = 1'b0;
  logic [4:0] vld, rdy;
  logic [4:0][31:0] dout, sat;

  always #5 clk = ~clk;

  fixed_clamp_act #(.DATA_IN_0_PARALLELISM_DIM_0(4), .DATA_OUT_0_PARALLELISM_DIM_0(4),
    .DATA_OUT_0_PRECISION_1(3), .MODE(1), .CLAMP_HI_INT(6)) u_r6 (
    .clk(clk), .rst(rst), .data_in_0(din), .data_in_0_valid(din_vld), .data_in_0_ready(rdy[0]),
    .data_out_0(dout[0]), .data_out_0_valid(vld[0]), .data_out_0_ready(dout_rdy), .sat_clr(sat_clr), .sat_count(sat[0]));
  fixed_clamp_act #(.DATA_IN_0_PARALLELISM_DIM_0(4), .DATA_OUT_0_PARALLELISM_DIM_0(4),
    .DATA_OUT_0_PRECISION_1(3), .MODE(2), .CLAMP_HI_INT(1)) u_ht (
    .clk(clk), .rst(rst), .data_in_0(din), .data_in_0_valid(din_vld), .data_in_0_ready(rdy[1]),
    .data_out_0(dout[1]), .data_out_0_valid(vld[1]), .data_out_0_ready(dout_rdy), .sat_clr(sat_clr), .sat_count(sat[1]));
  fixed_clamp_act #(.DATA_IN_0_PARALLELISM_DIM_0(4), .DATA_OUT_0_PARALLELISM_DIM_0(4),
    .DATA_OUT_0_PRECISION_1(4), .MODE(1), .CLAMP_HI_INT(6)) u_q4 (
    .clk(clk), .rst(rst), .data_in_0(din), .data_in_0_valid(din_vld), .data_in_0_ready(rdy[2]),
    .data_out_0(dout[2]), .data_out_0_valid(vld[2]), .data_out_0_ready(dout_rdy), .sat_clr(sat_clr), .sat_count(sat[2]));
  fixed_clamp_act #(.DATA_IN_0_PARALLELISM_DIM_0(4), .DATA_OUT_0_PARALLELISM_DIM_0(4),
    .DATA_OUT_0_PRECISION_1(5), .MODE(1), .CLAMP_HI_INT(6)) u_q5 (
    .clk(clk), .rst(rst), .data_in_0(din), .data_in_0_valid(din_vld), .data_in_0_ready(rdy[3]),
    .data_out_0(dout[3]), .data_out_0_valid(vld[3]), .data_out_0_ready(dout_rdy), .sat_clr(sat_clr), .sat_count(sat[3]));
  fixed_clamp_act #(.DATA_IN_0_PARALLELISM_DIM_0(4), .DATA_OUT_0_PARALLELISM_DIM_0(4),
    .DATA_OUT_0_PRECISION_1(1), .MODE(0), .CLAMP_HI_INT(6)) u_relu (
    .clk(clk), .rst(rst), .data_in_0(din), .data_in_0_valid(din_vld), .data_in_0_ready(rdy[4]),
    .data_out_0(dout[4]), .data_out_0_valid(vld[4]), .data_out_0_ready(dout_rdy), .sat_clr(sat_clr), .sat_count(sat[4]));

  typedef struct {
    logic [31:0] x;
    int          due;
  } beat_t;

  beat_t sb [$];
  logic [4:0][31:0] fired [$];
  logic [31:0] cnt [5];
  int checks = 0, failures = 0, cyc = 0;

  // Real-valued view: value/2^3 clamped to the mode's interval, rescaled to the output format, floored, saturated.
  function automatic logic [7:0] ref_lane(input logic [7:0] xin, input int k);
    int v, hi;
    v  = $signed(xin);
    hi = CFG_HI[k] * 8;
    if (CFG_MODE[k] == 2 && v < -hi)      v = -hi;
    else if (CFG_MODE[k] != 2 && v < 0)   v = 0;
    else if (CFG_MODE[k] != 0 && v > hi)  v = hi;
    if (CFG_OF[k] >= 3) v = v * (1 << (CFG_OF[k] - 3));
    else                v = v >>> (3 - CFG_OF[k]);
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v[7:0];
  endfunction

  function automatic logic [31:0] ref_beat(input logic [31:0] xin, input int k);
    logic [31:0] r;
    for (int l = 0; l < 4; l++) r[8*l +: 8] = ref_lane(xin[8*l +: 8], k);
    return r;
  endfunction

  function automatic bit hit_beat(input logic [31:0] xin, input int k);
    bit h = 0;
    for (int l = 0; l < 4; l++) begin
      logic [7:0] b;
      b = xin[8*l +: 8];
      if (CFG_MODE[k] != 0 && $signed(b) > CFG_HI[k] * 8) h = 1;
    end
    return h;
  endfunction

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, obs, exp);
    end
  endtask

  // One clock cycle: drive, check against the model, then advance the model across the edge.
  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic clr, output logic acc);
    logic exp_rdy, exp_vld, ofire;
    logic [4:0][31:0] snap;
    @(negedge clk);
    din = d; din_vld = v; dout_rdy = r; sat_clr = clr;
    #1;
    exp_rdy = (sb.size() < 2) || r;
    exp_vld = (sb.size() > 0) && (cyc >= sb[0].due);
    for (int i = 0; i < 5; i++) begin
      chk("ready", i, {31'd0, rdy[i]}, {31'd0, exp_rdy});
      chk("valid", i, {31'd0, vld[i]}, {31'd0, exp_vld});
      if (exp_vld) chk("data", i, dout[i], ref_beat(sb[0].x, i));
    end
    ofire = exp_vld && r;
    acc   = v && exp_rdy;
    if (ofire) begin
      for (int i = 0; i < 5; i++) begin
        snap[i] = dout[i];
        if (SAT_EN && !clr && hit_beat(sb[0].x, i) && cnt[i] != 32'hFFFF_FFFF) cnt[i] = cnt[i] + 1;
      end
      fired.push_back(snap);
      void'(sb.pop_front());
    end
    if (clr) for (int i = 0; i < 5; i++) cnt[i] = 0;
    if (acc) sb.push_back('{x: d, due: cyc + 2});
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < 5; i++) chk("sat_count", i, sat[i], cnt[i]);
  endtask

  initial begin
    logic acc, v;
    logic [31:0] d;
    for (int i = 0; i < 5; i++) cnt[i] = 0;

    // Reset state
    @(negedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("rst_valid", i, {31'd0, vld[i]}, 32'd0);
      chk("rst_data", i, dout[i], 32'd0);
      chk("rst_sat", i, sat[i], 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Directed: lane0 drives ReLU6 cases, lane1 drives hardtanh(1) cases
    step(1'b1, 32'h0000_F450, 1'b1, 1'b0, acc);
    step(1'b1, 32'h0000_0CF8, 1'b1, 1'b0, acc);
    step(1'b1, 32'h0000_FC15, 1'b1, 1'b0, acc);
    step(1'b1, 32'h0000_0030, 1'b1, 1'b0, acc);
    step(1'b0, 32'h0, 1'b1, 1'b0, acc);
    step(1'b0, 32'h0, 1'b1, 1'b0, acc);
    chk("dir_count", 0, fired.size(), 32'd4);
    if (fired.size() == 4) begin
      chk("r6_b0", 0, {24'd0, fired[0][0][7:0]}, 32'h30);
      chk("r6_b1", 0, {24'd0, fired[1][0][7:0]}, 32'h00);
      chk("r6_b2", 0, {24'd0, fired[2][0][7:0]}, 32'h15);
      chk("r6_b3", 0, {24'd0, fired[3][0][7:0]}, 32'h30);
      chk("ht_b0", 1, {24'd0, fired[0][1][15:8]}, 32'hF8);
      chk("ht_b1", 1, {24'd0, fired[1][1][15:8]}, 32'h08);
      chk("ht_b2", 1, {24'd0, fired[2][1][15:8]}, 32'hFC);
      chk("q4_b2", 2, {24'd0, fired[2][2][7:0]}, 32'h2A);
      chk("q4_b0", 2, {24'd0, fired[0][2][7:0]}, 32'h60);
      chk("q5_b0", 3, {24'd0, fired[0][3][7:0]}, 32'h7F);
    end
    chk("r6_sat", 0, sat[0], SAT_EN ? 32'd1 : 32'd0);

    // sat_clr coincident with the 4th clamped beat leaving
    step(1'b0, 32'h0, 1'b1, 1'b1, acc);
    for (int k = 0; k < 4; k++) step(1'b1, 32'h0000_0050, 1'b1, 1'b0, acc);
    step(1'b0, 32'h0, 1'b1, 1'b0, acc);
    chk("sat_pre_clr", 0, sat[0], SAT_EN ? 32'd3 : 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b1, acc);
    chk("sat_post_clr", 0, sat[0], 32'd0);

    // Random stream with random back-pressure; a pending beat is held until accepted
    v = 1'b0; d = '0; acc = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!v || acc) begin
        v = ($urandom_range(0, 3) != 0);
        d = $urandom;
      end
      step(v, d, $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0, acc);
    end
    for (int c = 0; c < 4; c++) step(1'b0, 32'h0, 1'b1, 1'b0, acc);

    // Fill both stages under a stall, then reset mid-stream
    step(1'b1, $urandom, 1'b0, 1'b0, acc);
    step(1'b1, 32'h5050_5050, 1'b0, 1'b0, acc);
    step(1'b1, $urandom, 1'b0, 1'b0, acc);
    @(negedge clk);
    rst = 1'b1; din_vld = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("midrst_valid", i, {31'd0, vld[i]}, 32'd0);
      chk("midrst_sat", i, sat[i], 32'd0);
    end
    sb.delete();
    for (int i = 0; i < 5; i++) cnt[i] = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) step(1'b0, 32'h0, 1'b1, 1'b0, acc);
    step(1'b1, 32'h1550_F830, 1'b1, 1'b0, acc);
    for (int c = 0; c < 3; c++) step(1'b0, 32'h0, 1'b1, 1'b0, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
